sha_result_checker: RTL and testbench
=====================================

// Module: sha_result_checker
// PURPOSE
// - Consumer at the output end of the golden_sha/hasher pipeline.
// - Takes the hash_o/validOut_o/newBlockOut_o stream and numbers each valid beat with a nonce. The nonce restarts at 0 on every newBlock beat.
// - Compares each hash against a 256-bit target and queues {blockId, nonce} of every hit in a small FIFO.
// - Hands the queued hits to the host over a valid/ready port.
// PARAMETERS
// - FIFO_DEPTH  4   result FIFO entries; power of 2, >=2
// - BLKID_W     8   width of the block identifier counter
// - DROP_W      8   width of the saturating dropped-hit counter
// PORTS
// - clk             in   1    clock
// - rst             in   1    asynchronous reset, active-high
// - validIn_i       in   1    hash beat valid (from hasher validOut_o)
// - newBlockIn_i    in   1    first beat of a new block (from newBlockOut_o)
// - hash_i          in   256  hash word, h0 in [255:224]
// - target_i        in   256  unsigned target; hit when hash_i <= target_i
// - resultValid_o   out  1    FIFO head valid
// - resultReady_i   in   1    host accepts head when resultValid_o && resultReady_i
// - resultNonce_o   out  32   nonce of head entry
// - resultBlkId_o   out  BLKID_W  blockId of head entry
// - active_o        out  1    at least one newBlock beat seen since reset
// - exhausted_o     out  1    one-cycle pulse: nonce wrapped 0xFFFFFFFF->0 within a block
// - dropCount_o     out  DROP_W  hits lost to FIFO full; saturating; cleared on newBlock
// BEHAVIOUR
// - Reset (async, immediate): every output is 0. State = IDLE, nonce=0, blkId=0, FIFO empty, stage1 invalid.
// - FSM, IDLE: beats with newBlockIn_i=0 are ignored (no nonce, no compare). valid&&newBlock -> ACTIVE.
// - FSM, ACTIVE: active_o=1. Leaves ACTIVE only on rst.
// - Beat counting: a valid beat is counted only when validIn_i=1.
// - Nonce and blkId per beat:
//   - valid && newBlock: beat nonce=0, blkId increments (the first block after reset gets blkId=1, wraps mod 2^BLKID_W), next nonce=1.
//   - valid && !newBlock in ACTIVE: beat nonce=current counter, then counter+1. 0xFFFFFFFF->0 wrap pulses exhausted_o at the next edge.
// - newBlockIn_i with validIn_i=0 has no effect.
// - Stage 1 (register, edge k): capture hit=(hash_i<=target_i), nonce, blkId, newBlock, valid.
// - Stage 2 (edge k+1), applied in order:
//   1. If stage1.newBlock: FIFO flushed and dropCount_o cleared. Stale hits of the prior block are discarded, including the last beat of the prior block pushed at edge k.
//   2. If stage1.valid&&hit: push {nonce, blkId}.
// - Latency: a hit beat sampled at edge k, with FIFO empty, gives resultValid_o=1 after edge k+1 (2-cycle latency).
// - FIFO operation:
//   - Head is shown first-word-fall-through; outputs are registered/from RAM head.
//   - Pop on resultValid_o&&resultReady_i.
//   - Push+pop in the same cycle is always legal, including when full.
//   - Full, no pop, push: hit dropped and dropCount_o incremented, saturating at all-ones.
//   - Pop on empty: ignored. Pointers wrap mod FIFO_DEPTH; a wrap bit distinguishes full from empty.
//   - Flush together with pop: flush wins, and the pop is lost. The host sees resultValid_o fall.
// - Host-side rule: resultNonce_o/resultBlkId_o hold stable while resultValid_o&&!resultReady_i.
// - Reset mid-block: all state cleared. The next beat must carry newBlock to leave IDLE.
// - target_i is sampled with the beat and may change per cycle.
// STRUCTURE
// - Package sha_check_pkg:
//   - typedef hash_t (logic[255:0])
//   - typedef nonce_t (logic[31:0])
//   - struct result_t {nonce_t nonce; logic[BLKID_W-1:0] blkId;}
//   - enum state_e {IDLE, ACTIVE}
//   - NONCE_MAX constant
// - One sub-module, result_fifo: parameterised sync FIFO of result_t with push/pop/flush, full/empty, FWFT head.
// - Top holds the FSM, counters, compare stage and drop counter.
// TESTING
// - Single hit: newBlock beat hash=0 target=1, then 3 non-hit beats (hash all-ones).
//   -> one entry nonce=0 blkId=1, resultValid_o rises 2 edges after the beat.
// - Hit pattern: newBlock, then hits on beats 2 and 5, host ready=1.
//   -> entries nonce=2 then nonce=5, in order, each for 1 cycle.
// - Overflow: FIFO_DEPTH=4, ready=0, 6 consecutive hit beats.
//   -> nonces 0..3 held, dropCount_o=2.
//   -> then ready=1: 0,1,2,3 popped, then resultValid_o=0.
// - Flush: 3 hits queued (ready=0), then a newBlock beat that is also a hit.
//   -> FIFO holds only nonce=0, blkId=2; dropCount_o=0.
// - Boundary: hash==target -> hit; hash==target+1 -> no hit. Beats in IDLE without newBlock -> no entries, active_o=0.
// - Async reset asserted mid-queue (2 entries, between edges) -> resultValid_o, active_o and dropCount_o are 0 immediately. After release, a non-newBlock hit beat pushes nothing.

Source files
------------

// File: rtl/sha_check_pkg.sv
// Shared types and constants for the SHA result checker: hash/nonce words,
// the queued result entry and the front-end state encoding.
package sha_check_pkg;

  localparam int RESULT_BLKID_W = 8;

  typedef logic [255:0] hash_t;
  typedef logic [31:0]  nonce_t;

  localparam nonce_t NONCE_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    nonce_t                    nonce;
    logic [RESULT_BLKID_W-1:0] blkId;
  } result_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/sha_result_checker_fifo.sv
// Synchronous FIFO with flush and a first-word-fall-through head. Flush wins
// over pop; a push in the flush cycle lands in the freshly emptied queue.
module result_fifo
  import sha_check_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = result_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output entry_t head_o,
  output logic   valid_o,
  output logic   full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, rd_q;
  entry_t      mem_q [DEPTH];
  logic        empty, do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty && !flush_i;
  assign do_push = push_i && (!full_o || do_pop || flush_i);
  assign valid_o = !empty;
  // Head is masked so that every output reads zero while the queue is empty.
  assign head_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= {{AW{1'b0}}, push_i};
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately left without reset; validity lives in the
  // pointers, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[flush_i ? '0 : wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sha_result_checker.sv
// Numbers hash beats with a per-block nonce, compares each against the target
// and queues {nonce, blkId} of hits for the host; counts hits lost to a full queue.
module sha_result_checker
  import sha_check_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BLKID_W    = 8,
  parameter int DROP_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validIn_i,
  input  logic               newBlockIn_i,
  input  hash_t              hash_i,
  input  hash_t              target_i,
  output logic               resultValid_o,
  input  logic               resultReady_i,
  output nonce_t             resultNonce_o,
  output logic [BLKID_W-1:0] resultBlkId_o,
  output logic               active_o,
  output logic               exhausted_o,
  output logic [DROP_W-1:0]  dropCount_o
);

  typedef struct packed {
    nonce_t             nonce;
    logic [BLKID_W-1:0] blkId;
  } entry_t;

  state_e             state_q;
  nonce_t             nonce_q;
  logic [BLKID_W-1:0] blkid_q, blkid_inc;
  logic               exhausted_q;

  logic               s1_valid_q, s1_new_q, s1_hit_q;
  nonce_t             s1_nonce_q;
  logic [BLKID_W-1:0] s1_blkid_q;

  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               flush, push, pop, fifo_full;
  entry_t             fifo_head;

  assign blkid_inc = blkid_q + BLKID_W'(1);

  // Front end: block/nonce numbering FSM and the compare stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      nonce_q     <= '0;
      blkid_q     <= '0;
      exhausted_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_new_q    <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_nonce_q  <= '0;
      s1_blkid_q  <= '0;
    end else begin
      exhausted_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_new_q    <= 1'b0;
      s1_hit_q    <= (hash_i <= target_i);
      if (validIn_i && newBlockIn_i) begin
        state_q    <= ACTIVE;
        blkid_q    <= blkid_inc;
        nonce_q    <= 32'd1;
        s1_valid_q <= 1'b1;
        s1_new_q   <= 1'b1;
        s1_nonce_q <= '0;
        s1_blkid_q <= blkid_inc;
      end else if (validIn_i && state_q == ACTIVE) begin
        nonce_q     <= nonce_q + 32'd1;
        exhausted_q <= (nonce_q == NONCE_MAX);
        s1_valid_q  <= 1'b1;
        s1_nonce_q  <= nonce_q;
        s1_blkid_q  <= blkid_q;
      end
    end
  end

  assign flush = s1_valid_q && s1_new_q;
  assign push  = s1_valid_q && s1_hit_q;
  assign pop   = resultValid_o && resultReady_i;

  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch on paths that do not update the counter.
  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      drop_d = '0;
    end else if (push && fifo_full && !pop && drop_q != {DROP_W{1'b1}}) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  result_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ('{nonce: s1_nonce_q, blkId: s1_blkid_q}),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (fifo_head),
    .valid_o (resultValid_o),
    .full_o  (fifo_full)
  );

  assign resultNonce_o = fifo_head.nonce;
  assign resultBlkId_o = fifo_head.blkId;
  assign active_o      = (state_q == ACTIVE);
  assign exhausted_o   = exhausted_q;
  assign dropCount_o   = drop_q;

endmodule

// File: tb/tb_sha_result_checker.sv
// Directed bench with a scoreboard: expected hits are queued as beats are
// issued and a monitor compares every entry the host pops.
module tb_sha_result_checker;
  import sha_check_pkg::*;

  typedef struct {
    logic [31:0] nonce;
    logic [7:0]  blk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         validIn = 1'b0, newBlock = 1'b0, ready = 1'b0;
  hash_t        hash = '0, target = '0;
  logic         resultValid, active, exhausted;
  logic [31:0]  resultNonce;
  logic [7:0]   resultBlkId, dropCount;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  localparam hash_t ONES = {256{1'b1}};
  localparam hash_t BIG  = {1'b1, 255'd0};

  sha_result_checker #(.FIFO_DEPTH(4), .BLKID_W(8), .DROP_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .validIn_i     (validIn),
    .newBlockIn_i  (newBlock),
    .hash_i        (hash),
    .target_i      (target),
    .resultValid_o (resultValid),
    .resultReady_i (ready),
    .resultNonce_o (resultNonce),
    .resultBlkId_o (resultBlkId),
    .active_o      (active),
    .exhausted_o   (exhausted),
    .dropCount_o   (dropCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic nb, input hash_t h, input hash_t t);
    validIn  = v;
    newBlock = nb;
    hash     = h;
    target   = t;
    @(posedge clk); #1;
    validIn  = 1'b0;
    newBlock = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_hit(input logic [31:0] n, input logic [7:0] b);
    exp_t e;
    e.nonce = n;
    e.blk   = b;
    sb.push_back(e);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid&&ready here.
  always @(negedge clk) begin
    if (!rst && resultValid && ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got nonce 0x%0h blkId 0x%0h, expected no entry", resultNonce, resultBlkId);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_nonce", 64'(resultNonce), 64'(e.nonce));
        check("pop_blkid", 64'(resultBlkId), 64'(e.blk));
      end
    end
  end

  initial begin
    // Reset state
    #3;
    check("rst_valid",   64'(resultValid), 64'd0);
    check("rst_active",  64'(active),      64'd0);
    check("rst_drop",    64'(dropCount),   64'd0);
    check("rst_exhaust", 64'(exhausted),   64'd0);
    check("rst_nonce",   64'(resultNonce), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Single hit with latency check (block 1)
    ready = 1'b0;
    beat(1'b1, 1'b1, '0, 256'd1);
    expect_hit(32'd0, 8'd1);
    check("s1_valid_k",  64'(resultValid), 64'd0);
    check("s1_active",   64'(active),      64'd1);
    beat(1'b1, 1'b0, ONES, 256'd1);
    check("s1_valid_k1", 64'(resultValid), 64'd1);
    check("s1_head_n",   64'(resultNonce), 64'd0);
    check("s1_head_b",   64'(resultBlkId), 64'd1);
    beat(1'b1, 1'b0, ONES, 256'd1);
    beat(1'b1, 1'b0, ONES, 256'd1);
    ready = 1'b1;
    idle(3);
    check("s1_sb_empty", 64'(sb.size()),  64'd0);
    check("s1_drained",  64'(resultValid), 64'd0);

    // Hits on beats 2 and 5, host always ready (block 2)
    beat(1'b1, 1'b1, ONES, 256'd7);
    for (int i = 1; i <= 5; i++) begin
      if (i == 2 || i == 5) begin
        beat(1'b1, 1'b0, 256'd3, 256'd7);
        expect_hit(32'(i), 8'd2);
      end else begin
        beat(1'b1, 1'b0, 256'd9, 256'd7);
      end
    end
    idle(4);
    check("s2_sb_empty", 64'(sb.size()),  64'd0);
    check("s2_drained",  64'(resultValid), 64'd0);

    // Overflow: six hits into a four-deep queue (block 3)
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, (i == 0), '0, ONES);
      if (i < 4) expect_hit(32'(i), 8'd3);
    end
    idle(2);
    check("s3_drop",     64'(dropCount),   64'd2);
    check("s3_head_n",   64'(resultNonce), 64'd0);
    idle(1);
    check("s3_hold_n",   64'(resultNonce), 64'd0);
    check("s3_hold_b",   64'(resultBlkId), 64'd3);
    ready = 1'b1;
    idle(6);
    check("s3_sb_empty", 64'(sb.size()),  64'd0);
    check("s3_drained",  64'(resultValid), 64'd0);
    check("s3_drop_kept", 64'(dropCount),  64'd2);

    // Flush: three queued hits (block 4), then a newBlock hit (block 5)
    ready = 1'b0;
    for (int i = 0; i < 3; i++) beat(1'b1, (i == 0), '0, 256'd5);
    idle(2);
    check("s4_drop_clr", 64'(dropCount),   64'd0);
    check("s4_pre_b",    64'(resultBlkId), 64'd4);
    sb.delete();
    beat(1'b1, 1'b1, 256'd5, 256'd5);
    expect_hit(32'd0, 8'd5);
    idle(2);
    check("s4_head_n",   64'(resultNonce), 64'd0);
    check("s4_head_b",   64'(resultBlkId), 64'd5);
    check("s4_drop",     64'(dropCount),   64'd0);
    ready = 1'b1;
    idle(3);
    check("s4_sb_empty", 64'(sb.size()),  64'd0);
    check("s4_one_only", 64'(resultValid), 64'd0);

    // Compare boundaries (block 6)
    beat(1'b1, 1'b1, 256'd5, 256'd5);
    expect_hit(32'd0, 8'd6);
    beat(1'b1, 1'b0, 256'd6, 256'd5);
    beat(1'b1, 1'b0, BIG, BIG);
    expect_hit(32'd2, 8'd6);
    beat(1'b1, 1'b0, BIG + 256'd1, BIG);
    beat(1'b1, 1'b0, {32'd1, 224'd0}, {32'd0, {224{1'b1}}});
    beat(1'b0, 1'b1, '0, ONES);
    beat(1'b1, 1'b0, {32'd0, {224{1'b1}}}, {32'd1, 224'd0});
    expect_hit(32'd5, 8'd6);
    idle(4);
    check("s5_sb_empty", 64'(sb.size()),  64'd0);
    check("s5_drained",  64'(resultValid), 64'd0);

    // Async reset between edges with a loaded queue and nonzero drop count
    ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(1'b1, (i == 0), '0, ONES);
    idle(2);
    check("s6_pre_valid", 64'(resultValid), 64'd1);
    check("s6_pre_drop",  64'(dropCount),   64'd2);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("s6_rst_valid",  64'(resultValid), 64'd0);
    check("s6_rst_active", 64'(active),      64'd0);
    check("s6_rst_drop",   64'(dropCount),   64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, '0, ONES);
    idle(3);
    check("s6_idle_valid",  64'(resultValid), 64'd0);
    check("s6_idle_active", 64'(active),      64'd0);
    ready = 1'b1;
    beat(1'b1, 1'b1, '0, ONES);
    expect_hit(32'd0, 8'd1);
    idle(4);
    check("s6_sb_empty", 64'(sb.size()), 64'd0);
    check("s6_active",   64'(active),    64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
